// File: rtl/wb_pkg.sv
// Shared writeback types: buffered result entry, source indices and the
// wrap-aware ROB age compare used by the flush logic.
`ifndef INSTR_ID_WIDTH
`define INSTR_ID_WIDTH 4
`endif
`ifndef PREG_RANGE
`define PREG_RANGE 5:0
`endif

package wb_pkg;
  localparam int WB_DATA_W = 64;
  localparam int ROBID_W   = `INSTR_ID_WIDTH + 1;
  localparam int NUM_SRC   = 3;

  typedef logic [`PREG_RANGE]   preg_t;
  typedef logic [ROBID_W-1:0]   robid_t;
  typedef logic [1:0]           src_idx_t;

  localparam src_idx_t ALU = 2'd0;
  localparam src_idx_t MUL = 2'd1;
  localparam src_idx_t LSU = 2'd2;

  typedef struct packed {
    logic                 need_to_wb;
    preg_t                prd;
    logic [WB_DATA_W-1:0] data;
    robid_t               robid;
  } wb_entry_t;

  // MSB is the wrap bit; a differing wrap bit inverts the index compare.
  function automatic logic robid_younger(input robid_t a, input robid_t b);
    logic [ROBID_W-2:0] ai, bi;
    ai = a[ROBID_W-2:0];
    bi = b[ROBID_W-2:0];
    return (a[ROBID_W-1] != b[ROBID_W-1]) ^ (ai > bi);
  endfunction
endpackage

// File: rtl/wb_src_buf.sv
// Two-entry flushable FIFO holding one source's results; entry 0 is the head.
module wb_src_buf
  import wb_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      in_valid,
  input  wb_entry_t in_entry,
  output logic      in_ready,
  input  logic      pop,
  input  logic      flush_valid,
  input  robid_t    flush_robid,
  output logic      head_valid,
  output wb_entry_t head
);
  wb_entry_t  ent_q [2];
  wb_entry_t  ent_d [2];
  logic [1:0] vld_q, vld_d;
  logic       push, keep0, keep1, keepn;

  assign in_ready   = ~&vld_q;
  assign push       = in_valid && in_ready;
  assign head_valid = vld_q[0];
  assign head       = ent_q[0];

  // Survivors (old head, old tail, incoming) are compacted in age order.
  always_comb begin
    keep0 = vld_q[0] && !pop && !(flush_valid && robid_younger(ent_q[0].robid, flush_robid));
    keep1 = vld_q[1] && !(flush_valid && robid_younger(ent_q[1].robid, flush_robid));
    keepn = push && !(flush_valid && robid_younger(in_entry.robid, flush_robid));
    ent_d[0] = keep0 ? ent_q[0] : (keep1 ? ent_q[1] : in_entry);
    ent_d[1] = (keep0 && keep1) ? ent_q[1] : in_entry;
    vld_d[0] = keep0 | keep1 | keepn;
    vld_d[1] = (keep0 & keep1) | (keep0 & keepn) | (keep1 & keepn);
  end

  always_ff @(posedge clock) begin
    if (reset) vld_q <= '0;
    else       vld_q <= vld_d;
    ent_q <= ent_d;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: three buffered sources onto two registered broadcast
// ports; ALU owns port 0 when present, MUL/LSU share the rest round-robin.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic                      alu_need_to_wb,
  input  logic [`PREG_RANGE]        alu_prd,
  input  logic [DATA_WIDTH-1:0]     alu_data,
  input  logic [`INSTR_ID_WIDTH:0]  alu_robid,
  input  logic                      mul_valid,
  output logic                      mul_ready,
  input  logic                      mul_need_to_wb,
  input  logic [`PREG_RANGE]        mul_prd,
  input  logic [DATA_WIDTH-1:0]     mul_data,
  input  logic [`INSTR_ID_WIDTH:0]  mul_robid,
  input  logic                      lsu_valid,
  output logic                      lsu_ready,
  input  logic                      lsu_need_to_wb,
  input  logic [`PREG_RANGE]        lsu_prd,
  input  logic [DATA_WIDTH-1:0]     lsu_data,
  input  logic [`INSTR_ID_WIDTH:0]  lsu_robid,
  output logic                      writeback0_valid,
  output logic                      writeback0_need_to_wb,
  output logic [`PREG_RANGE]        writeback0_prd,
  output logic [DATA_WIDTH-1:0]     writeback0_data,
  output logic [`INSTR_ID_WIDTH:0]  writeback0_robid,
  output logic                      writeback1_valid,
  output logic                      writeback1_need_to_wb,
  output logic [`PREG_RANGE]        writeback1_prd,
  output logic [DATA_WIDTH-1:0]     writeback1_data,
  output logic [`INSTR_ID_WIDTH:0]  writeback1_robid,
  input  logic                      flush_valid,
  input  logic [`INSTR_ID_WIDTH:0]  flush_robid
);
  if (BUF_DEPTH != 2) begin : g_bad_depth
    $error("wb_arbiter: only BUF_DEPTH=2 is supported");
  end
  if (DATA_WIDTH > WB_DATA_W) begin : g_bad_width
    $error("wb_arbiter: DATA_WIDTH exceeds wb_entry_t data field");
  end

  logic [NUM_SRC-1:0]      in_vld, in_rdy, head_vld, pop;
  wb_entry_t [NUM_SRC-1:0] in_ent, head;

  assign in_vld      = {lsu_valid, mul_valid, alu_valid};
  assign in_ent[ALU] = '{need_to_wb: alu_need_to_wb, prd: alu_prd, data: WB_DATA_W'(alu_data), robid: alu_robid};
  assign in_ent[MUL] = '{need_to_wb: mul_need_to_wb, prd: mul_prd, data: WB_DATA_W'(mul_data), robid: mul_robid};
  assign in_ent[LSU] = '{need_to_wb: lsu_need_to_wb, prd: lsu_prd, data: WB_DATA_W'(lsu_data), robid: lsu_robid};
  assign alu_ready   = in_rdy[ALU];
  assign mul_ready   = in_rdy[MUL];
  assign lsu_ready   = in_rdy[LSU];

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_buf
    wb_src_buf u_buf (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_vld[s]),
      .in_entry    (in_ent[s]),
      .in_ready    (in_rdy[s]),
      .pop         (pop[s]),
      .flush_valid (flush_valid),
      .flush_robid (flush_robid),
      .head_valid  (head_vld[s]),
      .head        (head[s])
    );
  end

  // rr_q: 0 favours MUL, 1 favours LSU
  logic           rr_q, rr_d, both;
  logic [1:0]     gnt_vld, gnt_live;
  src_idx_t [1:0] gnt_src;
  src_idx_t       rr_src, alt_src, win_src;

  always_comb begin
    both    = head_vld[MUL] && head_vld[LSU];
    rr_src  = rr_q ? LSU : MUL;
    alt_src = rr_q ? MUL : LSU;
    win_src = both ? rr_src : (head_vld[MUL] ? MUL : LSU);
    gnt_vld = '0;
    gnt_src = {MUL, ALU};
    rr_d    = rr_q;
    if (head_vld[ALU]) begin
      gnt_vld[0] = 1'b1;
      gnt_src[0] = ALU;
      gnt_vld[1] = head_vld[MUL] || head_vld[LSU];
      gnt_src[1] = win_src;
      if (both) rr_d = ~rr_q;  // one of the pair lost: point at it
    end else begin
      gnt_vld[0] = head_vld[MUL] || head_vld[LSU];
      gnt_src[0] = win_src;
      gnt_vld[1] = both;
      gnt_src[1] = alt_src;
    end
    pop      = '0;
    gnt_live = '0;
    for (int n = 0; n < 2; n++) begin
      if (gnt_vld[n]) pop[gnt_src[n]] = 1'b1;
      // flushed grants still pop but never reach the port
      gnt_live[n] = gnt_vld[n] &&
                    !(flush_valid && robid_younger(head[gnt_src[n]].robid, flush_robid));
    end
  end

  logic [1:0]      wb_vld_q;
  wb_entry_t [1:0] wb_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q     <= 1'b0;
      wb_vld_q <= '0;
    end else begin
      rr_q     <= rr_d;
      wb_vld_q <= gnt_live;
    end
    for (int n = 0; n < 2; n++) wb_q[n] <= head[gnt_src[n]];
  end

  assign writeback0_valid      = wb_vld_q[0];
  assign writeback0_need_to_wb = wb_q[0].need_to_wb;
  assign writeback0_prd        = wb_q[0].prd;
  assign writeback0_data       = wb_q[0].data[DATA_WIDTH-1:0];
  assign writeback0_robid      = wb_q[0].robid;
  assign writeback1_valid      = wb_vld_q[1];
  assign writeback1_need_to_wb = wb_q[1].need_to_wb;
  assign writeback1_prd        = wb_q[1].prd;
  assign writeback1_data       = wb_q[1].data[DATA_WIDTH-1:0];
  assign writeback1_robid      = wb_q[1].robid;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, latency, arbitration order, flush, mid-run reset.
module tb_wb_arbiter;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        alu_valid, alu_ready, alu_need_to_wb;
  logic [5:0]  alu_prd;
  logic [63:0] alu_data;
  logic [4:0]  alu_robid;
  logic        mul_valid, mul_ready, mul_need_to_wb;
  logic [5:0]  mul_prd;
  logic [63:0] mul_data;
  logic [4:0]  mul_robid;
  logic        lsu_valid, lsu_ready, lsu_need_to_wb;
  logic [5:0]  lsu_prd;
  logic [63:0] lsu_data;
  logic [4:0]  lsu_robid;
  logic        writeback0_valid, writeback0_need_to_wb;
  logic [5:0]  writeback0_prd;
  logic [63:0] writeback0_data;
  logic [4:0]  writeback0_robid;
  logic        writeback1_valid, writeback1_need_to_wb;
  logic [5:0]  writeback1_prd;
  logic [63:0] writeback1_data;
  logic [4:0]  writeback1_robid;
  logic        flush_valid;
  logic [4:0]  flush_robid;

  int checks = 0;
  int fails  = 0;

  wb_arbiter #(.DATA_WIDTH(64), .BUF_DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_need_to_wb(alu_need_to_wb),
    .alu_prd(alu_prd), .alu_data(alu_data), .alu_robid(alu_robid),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_need_to_wb(mul_need_to_wb),
    .mul_prd(mul_prd), .mul_data(mul_data), .mul_robid(mul_robid),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_need_to_wb(lsu_need_to_wb),
    .lsu_prd(lsu_prd), .lsu_data(lsu_data), .lsu_robid(lsu_robid),
    .writeback0_valid(writeback0_valid), .writeback0_need_to_wb(writeback0_need_to_wb),
    .writeback0_prd(writeback0_prd), .writeback0_data(writeback0_data), .writeback0_robid(writeback0_robid),
    .writeback1_valid(writeback1_valid), .writeback1_need_to_wb(writeback1_need_to_wb),
    .writeback1_prd(writeback1_prd), .writeback1_data(writeback1_data), .writeback1_robid(writeback1_robid),
    .flush_valid(flush_valid), .flush_robid(flush_robid)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_src(input int s, input logic v, input logic [4:0] rid, input logic [63:0] d);
    case (s)
      0: begin alu_valid = v; alu_need_to_wb = 1'b1; alu_prd = d[5:0]; alu_data = d; alu_robid = rid; end
      1: begin mul_valid = v; mul_need_to_wb = 1'b1; mul_prd = d[5:0]; mul_data = d; mul_robid = rid; end
      default: begin lsu_valid = v; lsu_need_to_wb = 1'b1; lsu_prd = d[5:0]; lsu_data = d; lsu_robid = rid; end
    endcase
  endtask

  task automatic idle_inputs();
    for (int s = 0; s < 3; s++) set_src(s, 1'b0, 5'd0, 64'd0);
    flush_valid = 1'b0;
    flush_robid = 5'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL reset_alu_ready: got %b want 1", alu_ready); end
    checks++; if (mul_ready !== 1'b1) begin fails++; $display("FAIL reset_mul_ready: got %b want 1", mul_ready); end
    checks++; if (lsu_ready !== 1'b1) begin fails++; $display("FAIL reset_lsu_ready: got %b want 1", lsu_ready); end
    checks++; if (writeback0_valid !== 1'b0) begin fails++; $display("FAIL reset_wb0_valid: got %b want 0", writeback0_valid); end
    checks++; if (writeback1_valid !== 1'b0) begin fails++; $display("FAIL reset_wb1_valid: got %b want 0", writeback1_valid); end
  endtask

  task automatic test_single_alu();
    do_reset();
    set_src(0, 1'b1, 5'd3, 64'hABC5);
    alu_prd = 6'd5;
    checks++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL single_ready: got %b want 1", alu_ready); end
    step();
    idle_inputs();
    checks++; if (writeback0_valid !== 1'b0) begin fails++; $display("FAIL single_c1_wb0_valid: got %b want 0", writeback0_valid); end
    step();
    checks++; if (writeback0_valid !== 1'b1) begin fails++; $display("FAIL single_c2_wb0_valid: got %b want 1", writeback0_valid); end
    checks++; if (writeback0_prd !== 6'd5) begin fails++; $display("FAIL single_c2_prd: got %0d want 5", writeback0_prd); end
    checks++; if (writeback0_robid !== 5'd3) begin fails++; $display("FAIL single_c2_robid: got %0d want 3", writeback0_robid); end
    checks++; if (writeback0_data !== 64'hABC5) begin fails++; $display("FAIL single_c2_data: got %h want abc5", writeback0_data); end
    checks++; if (writeback1_valid !== 1'b0) begin fails++; $display("FAIL single_c2_wb1_valid: got %b want 0", writeback1_valid); end
    step();
    checks++; if (writeback0_valid !== 1'b0) begin fails++; $display("FAIL single_c3_wb0_valid: got %b want 0", writeback0_valid); end
  endtask

  task automatic test_all_sources();
    logic [63:0] exp0 [10] = '{64'h0, 64'h0, 64'h100, 64'h101, 64'h102, 64'h103, 64'h104, 64'h105, 64'h203, 64'h0};
    logic [63:0] exp1 [10] = '{64'h0, 64'h0, 64'h200, 64'h300, 64'h201, 64'h301, 64'h202, 64'h302, 64'h303, 64'h0};
    logic [5:0] exp_mrdy = 6'b010111;
    logic [5:0] exp_lrdy = 6'b101011;
    int aseq = 0, mseq = 0, lseq = 0;
    logic acc_a, acc_m, acc_l;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      set_src(0, c < 6, 5'(aseq), 64'h100 + 64'(aseq));
      set_src(1, c < 6, 5'(mseq), 64'h200 + 64'(mseq));
      set_src(2, c < 6, 5'(lseq), 64'h300 + 64'(lseq));
      if (c < 6) begin
        checks++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL all_c%0d_alu_ready: got %b want 1", c, alu_ready); end
        checks++; if (mul_ready !== exp_mrdy[c]) begin fails++; $display("FAIL all_c%0d_mul_ready: got %b want %b", c, mul_ready, exp_mrdy[c]); end
        checks++; if (lsu_ready !== exp_lrdy[c]) begin fails++; $display("FAIL all_c%0d_lsu_ready: got %b want %b", c, lsu_ready, exp_lrdy[c]); end
      end
      checks++; if (writeback0_valid !== (exp0[c] != 0)) begin fails++; $display("FAIL all_c%0d_wb0_valid: got %b want %b", c, writeback0_valid, exp0[c] != 0); end
      checks++; if (writeback1_valid !== (exp1[c] != 0)) begin fails++; $display("FAIL all_c%0d_wb1_valid: got %b want %b", c, writeback1_valid, exp1[c] != 0); end
      if (exp0[c] != 0) begin
        checks++; if (writeback0_data !== exp0[c]) begin fails++; $display("FAIL all_c%0d_wb0_data: got %h want %h", c, writeback0_data, exp0[c]); end
      end
      if (exp1[c] != 0) begin
        checks++; if (writeback1_data !== exp1[c]) begin fails++; $display("FAIL all_c%0d_wb1_data: got %h want %h", c, writeback1_data, exp1[c]); end
      end
      acc_a = alu_valid && alu_ready;
      acc_m = mul_valid && mul_ready;
      acc_l = lsu_valid && lsu_ready;
      step();
      if (acc_a) aseq++;
      if (acc_m) mseq++;
      if (acc_l) lseq++;
    end
    idle_inputs();
    checks++; if (aseq != 6) begin fails++; $display("FAIL all_alu_accepted: got %0d want 6", aseq); end
    checks++; if (mseq != 4) begin fails++; $display("FAIL all_mul_accepted: got %0d want 4", mseq); end
    checks++; if (lseq != 4) begin fails++; $display("FAIL all_lsu_accepted: got %0d want 4", lseq); end
  endtask

  task automatic test_mul_lsu();
    do_reset();
    set_src(1, 1'b1, 5'd1, 64'h2AA);
    set_src(2, 1'b1, 5'd2, 64'h3BB);
    step();
    idle_inputs();
    step();
    checks++; if (writeback0_valid !== 1'b1 || writeback0_data !== 64'h2AA) begin fails++; $display("FAIL mullsu_wb0: got v=%b d=%h want v=1 d=2aa", writeback0_valid, writeback0_data); end
    checks++; if (writeback1_valid !== 1'b1 || writeback1_data !== 64'h3BB) begin fails++; $display("FAIL mullsu_wb1: got v=%b d=%h want v=1 d=3bb", writeback1_valid, writeback1_data); end
    step();
    checks++; if (writeback0_valid !== 1'b0 || writeback1_valid !== 1'b0) begin fails++; $display("FAIL mullsu_c3_idle: got %b%b want 00", writeback0_valid, writeback1_valid); end
  endtask

  task automatic test_flush_buffered();
    do_reset();
    set_src(0, 1'b1, 5'd1, 64'h101);
    set_src(1, 1'b1, 5'd5, 64'h205);
    set_src(2, 1'b1, 5'd6, 64'h306);
    step();
    set_src(0, 1'b1, 5'd2, 64'h102);
    set_src(1, 1'b1, 5'd9, 64'h209);
    set_src(2, 1'b0, 5'd0, 64'h0);
    step();
    set_src(0, 1'b1, 5'd3, 64'h103);
    set_src(1, 1'b1, 5'd12, 64'h20C);
    checks++; if (writeback1_valid !== 1'b1 || writeback1_data !== 64'h205) begin fails++; $display("FAIL flushbuf_c2_wb1: got v=%b d=%h want v=1 d=205", writeback1_valid, writeback1_data); end
    step();
    idle_inputs();
    flush_valid = 1'b1;
    flush_robid = 5'd10;
    checks++; if (mul_ready !== 1'b0) begin fails++; $display("FAIL flushbuf_c3_mul_full: got %b want 0", mul_ready); end
    checks++; if (writeback1_valid !== 1'b1 || writeback1_data !== 64'h306) begin fails++; $display("FAIL flushbuf_c3_wb1: got v=%b d=%h want v=1 d=306", writeback1_valid, writeback1_data); end
    step();
    flush_valid = 1'b0;
    checks++; if (writeback0_valid !== 1'b1 || writeback0_data !== 64'h103) begin fails++; $display("FAIL flushbuf_c4_wb0: got v=%b d=%h want v=1 d=103", writeback0_valid, writeback0_data); end
    checks++; if (writeback1_valid !== 1'b1 || writeback1_robid !== 5'd9) begin fails++; $display("FAIL flushbuf_c4_rob9: got v=%b rob=%0d want v=1 rob=9", writeback1_valid, writeback1_robid); end
    for (int c = 5; c < 9; c++) begin
      step();
      checks++; if (writeback0_valid !== 1'b0 || writeback1_valid !== 1'b0) begin fails++; $display("FAIL flushbuf_c%0d_rob12_leak: got %b%b want 00", c, writeback0_valid, writeback1_valid); end
    end
  endtask

  task automatic test_flush_accept();
    do_reset();
    flush_valid = 1'b1;
    flush_robid = 5'd10;
    set_src(2, 1'b1, 5'd10, 64'h3AA);
    lsu_need_to_wb = 1'b0;
    set_src(1, 1'b1, 5'd11, 64'h2BB);
    step();
    idle_inputs();
    step();
    checks++; if (writeback0_valid !== 1'b1 || writeback0_robid !== 5'd10) begin fails++; $display("FAIL flushacc_wb0: got v=%b rob=%0d want v=1 rob=10", writeback0_valid, writeback0_robid); end
    checks++; if (writeback0_need_to_wb !== 1'b0) begin fails++; $display("FAIL flushacc_ntw: got %b want 0", writeback0_need_to_wb); end
    checks++; if (writeback1_valid !== 1'b0) begin fails++; $display("FAIL flushacc_wb1_valid: got %b want 0", writeback1_valid); end
    step();
    checks++; if (writeback0_valid !== 1'b0 || writeback1_valid !== 1'b0) begin fails++; $display("FAIL flushacc_c3_idle: got %b%b want 00", writeback0_valid, writeback1_valid); end
  endtask

  task automatic test_flush_wrap();
    do_reset();
    set_src(0, 1'b1, 5'b10001, 64'h1EE);
    set_src(2, 1'b1, 5'b01101, 64'h3DD);
    step();
    idle_inputs();
    flush_valid = 1'b1;
    flush_robid = 5'b01110;
    step();
    flush_valid = 1'b0;
    checks++; if (writeback0_valid !== 1'b0) begin fails++; $display("FAIL wrap_wb0_dropped: got %b want 0", writeback0_valid); end
    checks++; if (writeback1_valid !== 1'b1 || writeback1_robid !== 5'b01101) begin fails++; $display("FAIL wrap_wb1_kept: got v=%b rob=%0d want v=1 rob=13", writeback1_valid, writeback1_robid); end
    step();
    checks++; if (writeback0_valid !== 1'b0 || writeback1_valid !== 1'b0) begin fails++; $display("FAIL wrap_c3_idle: got %b%b want 00", writeback0_valid, writeback1_valid); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_src(0, 1'b1, 5'(c), 64'h100 + 64'(c));
      set_src(1, 1'b1, 5'(c), 64'h200 + 64'(c));
      set_src(2, 1'b1, 5'(c), 64'h300 + 64'(c));
      step();
    end
    idle_inputs();
    checks++; if (writeback0_valid !== 1'b1) begin fails++; $display("FAIL midrst_busy: got %b want 1", writeback0_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (writeback0_valid !== 1'b0 || writeback1_valid !== 1'b0) begin fails++; $display("FAIL midrst_valids: got %b%b want 00", writeback0_valid, writeback1_valid); end
    checks++; if ({alu_ready, mul_ready, lsu_ready} !== 3'b111) begin fails++; $display("FAIL midrst_ready: got %b want 111", {alu_ready, mul_ready, lsu_ready}); end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (writeback0_valid !== 1'b0 || writeback1_valid !== 1'b0) begin fails++; $display("FAIL midrst_c%0d_leak: got %b%b want 00", c, writeback0_valid, writeback1_valid); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_alu();
    test_all_sources();
    test_mul_lsu();
    test_flush_buffered();
    test_flush_accept();
    test_flush_wrap();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
